// File: rtl/multi_inout_manager.sv
// Multi-channel DDR data capture with per-channel envelope synchronizer and edge detect.
// Define INOUT_ENV_FILTER_EN to compile in the per-channel envelope stability filter.
module multi_inout_manager #(
  parameter int unsigned N_CHANNELS     = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned ENV_FILTER_LEN = 4
) (
  input  logic                    clk_96MHz,
  input  logic                    rst_n,
  input  logic [N_CHANNELS-1:0]   data_wire,
  input  logic [N_CHANNELS-1:0]   envelop_wire,
  output logic [2*N_CHANNELS-1:0] d_pair,
  output logic [N_CHANNELS-1:0]   e_out,
  output logic [N_CHANNELS-1:0]   e_rise,
  output logic [N_CHANNELS-1:0]   e_fall
);

  logic [N_CHANNELS-1:0]   neg_cap_q;
  logic [2*N_CHANNELS-1:0] pair_d;
  logic [2*N_CHANNELS-1:0] pair_q [SYNC_STAGES];
  logic [N_CHANNELS-1:0]   env_sync_q [SYNC_STAGES];
  logic [N_CHANNELS-1:0]   e_sync;
  logic [N_CHANNELS-1:0]   e_out_d, e_out_q;
  logic [N_CHANNELS-1:0]   e_rise_q, e_fall_q;

  always_ff @(negedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      neg_cap_q <= '0;
    end else begin
      neg_cap_q <= data_wire;
    end
  end

  // Stage 0 holds {pos_cap, neg_hold}; even bit is the earlier (negedge) sample.
  always_comb begin
    pair_d = '0;
    for (int i = 0; i < int'(N_CHANNELS); i++) begin
      pair_d[2*i]   = neg_cap_q[i];
      pair_d[2*i+1] = data_wire[i];
    end
  end

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        pair_q[s]     <= '0;
        env_sync_q[s] <= '0;
      end
    end else begin
      pair_q[0]     <= pair_d;
      env_sync_q[0] <= envelop_wire;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        pair_q[s]     <= pair_q[s-1];
        env_sync_q[s] <= env_sync_q[s-1];
      end
    end
  end

  assign d_pair = pair_q[SYNC_STAGES-1];
  assign e_sync = env_sync_q[SYNC_STAGES-1];

`ifdef INOUT_ENV_FILTER_EN
  localparam logic [7:0] FilterLen = 8'(ENV_FILTER_LEN);

  logic [7:0] cnt_q [N_CHANNELS];
  logic [7:0] cnt_d [N_CHANNELS];
  logic [7:0] cnt_inc [N_CHANNELS];

  // A channel's output follows e_sync only after FilterLen consecutive deviating cycles.
  always_comb begin
    e_out_d = e_out_q;
    for (int i = 0; i < int'(N_CHANNELS); i++) begin
      cnt_d[i]   = 8'd0;
      cnt_inc[i] = (cnt_q[i] == 8'hff) ? 8'hff : cnt_q[i] + 8'd1;
      if (e_sync[i] != e_out_q[i]) begin
        if (cnt_inc[i] == FilterLen) begin
          e_out_d[i] = e_sync[i];
        end else begin
          cnt_d[i] = cnt_inc[i];
        end
      end
    end
  end

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CHANNELS); i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < int'(N_CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  logic unused_filter_len;
  assign unused_filter_len = ^ENV_FILTER_LEN;

  always_comb begin
    e_out_d = e_sync;
  end
`endif

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      e_out_q  <= '0;
      e_rise_q <= '0;
      e_fall_q <= '0;
    end else begin
      e_out_q  <= e_out_d;
      e_rise_q <= e_out_d & ~e_out_q;
      e_fall_q <= ~e_out_d & e_out_q;
    end
  end

  assign e_out  = e_out_q;
  assign e_rise = e_rise_q;
  assign e_fall = e_fall_q;

endmodule

// File: tb/tb_multi_inout_manager.sv
// Self-checking bench for multi_inout_manager: directed envelope/reset scenarios plus
// randomized DDR data and envelope runs compared against a sample-history model.
module tb_multi_inout_manager;

  localparam int N   = 4;
  localparam int S   = 2;
  localparam int LEN = 4;

  logic           clk_96MHz = 1'b0;
  logic           rst_n;
  logic [N-1:0]   data_wire;
  logic [N-1:0]   envelop_wire;
  logic [2*N-1:0] d_pair;
  logic [N-1:0]   e_out, e_rise, e_fall;

  multi_inout_manager #(
    .N_CHANNELS    (N),
    .SYNC_STAGES   (S),
    .ENV_FILTER_LEN(LEN)
  ) dut (
    .clk_96MHz   (clk_96MHz),
    .rst_n       (rst_n),
    .data_wire   (data_wire),
    .envelop_wire(envelop_wire),
    .d_pair      (d_pair),
    .e_out       (e_out),
    .e_rise      (e_rise),
    .e_fall      (e_fall)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  int n_cmp = 0;
  int n_err = 0;
  int rise1_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: histories of raw samples since reset, indexed by pipeline depth.
  logic [N-1:0]   last_neg;
  logic [2*N-1:0] pair_hist [$];
  logic [N-1:0]   env_hist [$];
  logic [N-1:0]   eo_m, rise_m, fall_m;
  int             dev_run [N];

  function automatic logic [2*N-1:0] mk_pair(input logic [N-1:0] pos, input logic [N-1:0] neg);
    logic [2*N-1:0] p;
    for (int i = 0; i < N; i++) begin
      p[2*i]   = neg[i];
      p[2*i+1] = pos[i];
    end
    return p;
  endfunction

  function automatic logic [2*N-1:0] exp_dpair();
    if (pair_hist.size() >= S) return pair_hist[pair_hist.size()-S];
    return '0;
  endfunction

  function automatic logic [N-1:0] esync_now();
    if (env_hist.size() >= S) return env_hist[env_hist.size()-S];
    return '0;
  endfunction

  task automatic model_clear();
    last_neg = '0;
    pair_hist.delete();
    env_hist.delete();
    eo_m   = '0;
    rise_m = '0;
    fall_m = '0;
    for (int i = 0; i < N; i++) dev_run[i] = 0;
  endtask

  task automatic model_posedge();
    logic [N-1:0] es, nxt;
    es = esync_now();
    pair_hist.push_back(mk_pair(data_wire, last_neg));
    env_hist.push_back(envelop_wire);
    if (pair_hist.size() > 8) void'(pair_hist.pop_front());
    if (env_hist.size() > 8) void'(env_hist.pop_front());
    nxt = eo_m;
`ifdef INOUT_ENV_FILTER_EN
    for (int i = 0; i < N; i++) begin
      if (es[i] != eo_m[i]) begin
        dev_run[i]++;
        if (dev_run[i] == LEN) begin
          nxt[i] = es[i];
          dev_run[i] = 0;
        end
      end else begin
        dev_run[i] = 0;
      end
    end
`else
    nxt = es;
`endif
    rise_m = nxt & ~eo_m;
    fall_m = ~nxt & eo_m;
    eo_m   = nxt;
  endtask

  // One clock cycle: dn sampled at the negedge, dp/env sampled at the following posedge.
  task automatic step(input logic [N-1:0] dn, input logic [N-1:0] dp, input logic [N-1:0] env);
    data_wire = dn;
    @(negedge clk_96MHz);
    if (rst_n) last_neg = data_wire;
    #2;
    data_wire    = dp;
    envelop_wire = env;
    @(posedge clk_96MHz);
    model_posedge();
    #1;
    check_val("d_pair", 32'(d_pair), 32'(exp_dpair()));
    check_val("e_out", 32'(e_out), 32'(eo_m));
    check_val("e_rise", 32'(e_rise), 32'(rise_m));
    check_val("e_fall", 32'(e_fall), 32'(fall_m));
    check_val("rise_fall_excl", 32'(e_rise & e_fall), 32'd0);
    if (e_rise[1]) rise1_cnt++;
  endtask

  // Called at posedge+1; holds reset low for 3 ns, mid-cycle.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_d_pair", 32'(d_pair), 32'd0);
    check_val("rst_e_out", 32'(e_out), 32'd0);
    check_val("rst_e_rise", 32'(e_rise), 32'd0);
    check_val("rst_e_fall", 32'(e_fall), 32'd0);
    #2;
    rst_n = 1'b1;
    model_clear();
  endtask

  logic [N-1:0] env_cur;
  int           hold [N];

  initial begin
    rst_n        = 1'b0;
    data_wire    = '0;
    envelop_wire = '0;
    model_clear();
    repeat (3) @(posedge clk_96MHz);
    #1;
    pulse_reset();

    // Channel 0 toggles each half cycle: 1 at negedge, 0 at posedge.
    for (int k = 0; k < 6; k++) begin
      step(4'b0001, 4'b0000, '0);
      if (k >= 1) check_val("ddr_toggle", 32'(d_pair[1:0]), 32'd1);
    end

    // Channel 1 envelope: 3-cycle burst, then 4-cycle burst.
    repeat (10) step('0, '0, '0);
    rise1_cnt = 0;
    repeat (3) step('0, '0, 4'b0010);
    repeat (10) step('0, '0, '0);
`ifdef INOUT_ENV_FILTER_EN
    check_val("short_burst_rises", 32'(rise1_cnt), 32'd0);
`else
    check_val("short_burst_rises", 32'(rise1_cnt), 32'd1);
`endif
    rise1_cnt = 0;
    repeat (4) step('0, '0, 4'b0010);
    repeat (10) step('0, '0, '0);
    check_val("long_burst_rises", 32'(rise1_cnt), 32'd1);

    // Independent glitches: channel 0 above LEN, channel 1 below.
    repeat (2) step('0, '0, 4'b0011);
    repeat (3) step('0, '0, 4'b0001);
    repeat (10) step('0, '0, '0);

    // All inputs high, reset pulsed mid-cycle, pipeline refills.
    repeat (8) step('1, '1, '1);
    pulse_reset();
    step('1, '1, '1);
    step('1, '1, '1);
    check_val("refill_all_ones", 32'(d_pair), 32'hff);
    repeat (8) step('1, '1, '1);

    // Randomized data and envelope runs.
    env_cur = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          env_cur[i] = 1'($urandom_range(0, 1));
          hold[i]    = $urandom_range(1, 6);
        end
        hold[i]--;
      end
      step(N'($urandom), N'($urandom), env_cur);
      if (k == 200) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_inout_manager.md
MULTI_INOUT_MANAGER -- requirements
Module: multi_inout_manager

Interface
REQ-001 Parameter N_CHANNELS, default 4, SHALL set the number of sensor channels (legal 1..16).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the posedge synchronizer depth for both data and envelope paths (legal 2..4).
REQ-003 Parameter ENV_FILTER_LEN, default 4, SHALL set the envelope stability count in clk_96MHz cycles (legal 1..255).
REQ-004 clk_96MHz  input  1  SHALL be the sole clock; data is captured on both edges.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 data_wire  input  N_CHANNELS  SHALL carry the raw sensor data lines, one bit per channel.
REQ-007 envelop_wire  input  N_CHANNELS  SHALL carry the raw sensor envelope lines, one bit per channel.
REQ-008 d_pair  output  2*N_CHANNELS  SHALL carry per-channel DDR sample pairs: bit 2i is the earlier (negedge) sample and bit 2i+1 is the later (posedge) sample of channel i.
REQ-009 e_out  output  N_CHANNELS  SHALL carry the synchronized, optionally filtered, envelope per channel.
REQ-010 e_rise  output  N_CHANNELS  SHALL pulse high for one cycle when e_out[i] changes 0->1.
REQ-011 e_fall  output  N_CHANNELS  SHALL pulse high for one cycle when e_out[i] changes 1->0.

Function
REQ-012 Each channel SHALL capture data_wire[i] into a negedge register neg_cap and, at each posedge, capture data_wire[i] into pos_cap and transfer neg_cap into neg_hold.
REQ-013 The pair {pos_cap, neg_hold} SHALL pass through SYNC_STAGES-1 further posedge register stages before driving d_pair; a posedge sample taken at edge k SHALL be visible on d_pair after edge k+SYNC_STAGES-1, paired with the negedge sample taken half a cycle before edge k.
REQ-014 The data path SHALL be lossless: every posedge cycle presents exactly two new samples per channel, with no gaps or duplicates.
REQ-015 envelop_wire[i] SHALL pass through a SYNC_STAGES-deep posedge synchronizer producing e_sync[i].
REQ-016 Each envelope channel SHALL have its own 8-bit stability counter, with no cross-channel coupling.
REQ-017 With filtering compiled in: when e_sync[i] equals e_out[i], the counter SHALL clear to 0.
REQ-018 With filtering compiled in: when e_sync[i] differs from e_out[i], the counter SHALL increment.
REQ-019 With filtering compiled in: on the cycle the counter would reach ENV_FILTER_LEN, e_out[i] SHALL take e_sync[i] and the counter SHALL clear.
REQ-020 A deviation lasting fewer than ENV_FILTER_LEN cycles SHALL leave e_out unchanged.
REQ-021 A deviation lasting exactly ENV_FILTER_LEN consecutive cycles SHALL toggle e_out.
REQ-022 e_rise/e_fall SHALL be registered and asserted in the same cycle in which e_out shows its new value, and SHALL deassert the next cycle unless e_out toggles again.
REQ-023 e_rise[i] and e_fall[i] SHALL never be high simultaneously.
REQ-024 The stability counter SHALL saturate at 255 and never wrap.

Reset
REQ-025 While rst_n=0: d_pair, e_out, e_rise, e_fall, all capture and synchronizer registers (both clock edges), and all counters SHALL be 0.
REQ-026 Reset assertion mid-operation SHALL clear state immediately, independent of clock.
REQ-027 After rst_n rises, d_pair SHALL show 0 until the synchronizer pipeline refills (SYNC_STAGES posedges).
REQ-028 After rst_n rises, no e_rise pulse SHALL be produced by the reset release itself; e_rise SHALL occur only through REQ-019 with a high envelope input.

Configuration
REQ-029 Macro INOUT_ENV_FILTER_EN defined: envelope filtering per REQ-017 to REQ-021 SHALL be compiled in.
REQ-030 Macro INOUT_ENV_FILTER_EN undefined: counters SHALL be omitted, e_out SHALL equal e_sync delayed by one register, ENV_FILTER_LEN SHALL be ignored, and e_rise/e_fall SHALL follow e_out per REQ-022.

Verification
REQ-031 N=4, S=2, data_wire[0] toggling every half cycle, starting 1 at negedge before edge 10 -> after edge 11, d_pair[1:0]=2'b01 and d_pair[1:0] stays 2'b01 every cycle thereafter.
REQ-032 S=3, data_wire[2] static 1 from before edge 5 -> d_pair[5:4]=2'b11 after edge 7, and not before.
REQ-033 FILTER_EN, LEN=4, envelop_wire[1] high for 3 cycles then low -> e_out[1]=0, e_rise[1] never pulses; high for 4 cycles -> e_out[1]=1 with a single e_rise[1] pulse.
REQ-034 Filter compiled out, envelop_wire[3] 0->1 at edge 20 -> e_out[3]=1 after edge 23 (S=2), e_rise[3] high for exactly that cycle.
REQ-035 All inputs high, rst_n pulsed low for 3 ns mid-cycle -> all outputs 0 immediately, d_pair all ones again after 2 posedges (S=2), with e_rise following only via the filter.
REQ-036 Channels 0 and 1 envelopes glitching independently, one above and one below LEN -> only the channel with the qualifying deviation changes e_out.
